x68k_ldr_sink: RTL and testbench
================================

# x68k_ldr_sink

Responder end of the loader byte-write handshake (`ldr_wr` / `ldr_ack`) on the X68000 core. It accepts ROM/image bytes from the HPS-side loader and packs consecutive even/odd byte pairs into big-endian 16-bit words. It issues one write per word to the SDRAM arbiter's loader port and acknowledges each byte back to the loader. It sits inside the core between the top-level loader glue and the RAM arbiter, and runs only while the loader window (`ldr_aen`) is open.

## Interface
Parameters:
- `ADDR_W`, default 20: byte address width of `ldr_addr`; the RAM word address is `ADDR_W-1` bits.

Ports (one clock; reset is asynchronous and active-low):
- `sysclk`  in  1  system clock; all logic is on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `ldr_aen`  in  1  loader window open; its falling edge flushes any held byte.
- `ldr_addr`  in  ADDR_W  byte address; bit 0 = 0 is an even (upper) byte.
- `ldr_wdat`  in  8  byte data.
- `ldr_wr`  in  1  level request, held by the loader until it sees `ldr_ack`.
- `ldr_ack`  out  1  one-cycle byte-commit pulse.
- `ram_req`  out  1  write request, held until `ram_ack`.
- `ram_ack`  in  1  one-cycle completion from the arbiter.
- `ram_addr`  out  ADDR_W-1  word address.
- `ram_wdat`  out  16  word data; even byte in [15:8].
- `ram_be`  out  2  byte enables: [1] = upper, [0] = lower.
- `busy`  out  1  high when not in IDLE.
- `csum`  out  16  running byte sum (see Configuration).

## Operation
- Reset values: every output is 0, the held-byte register is cleared, state = IDLE, `armed` = 1.
- Re-arm rule: a request is accepted only when `ldr_wr & ldr_aen & armed`.
  - `armed` clears on accept.
  - `armed` sets on any cycle where `ldr_wr` = 0.
  - This prevents a still-high `ldr_wr` from being accepted twice after the ack.
- States:
  - IDLE: no byte held.
    - Even byte accepted: latch it into `hold_addr` / `hold_dat`, pulse `ldr_ack`, go to HOLD.
    - Odd byte accepted: go to WRITE with `be` = 01 and data {8'h00, byte}; the ack is deferred.
  - HOLD: one even byte held.
    - Odd byte with `addr[ADDR_W-1:1]` equal to the held word: WRITE with `be` = 11 and data {held, byte}; ack deferred.
    - Any other byte (new even byte, or odd byte of a different word): WRITE flushing the held byte with `be` = 10, no ack. The new byte stays latched as pending and is processed from IDLE after the flush; it is acked per the IDLE rules.
    - `ldr_aen` = 0: WRITE flush with `be` = 10, no ack.
  - WRITE: `ram_req` = 1, with `ram_addr` / `ram_wdat` / `ram_be` held stable.
    - On `ram_ack`: drop `ram_req` and pulse `ldr_ack` if the write owed one, then go to IDLE, or to the pending-byte path if a byte is pending.
- `ram_wdat` bits belonging to disabled lanes are 0.
- While `ldr_aen` = 0, `ldr_wr` is ignored. An in-flight WRITE still completes.

## Timing
- Even byte: accepted on cycle N; `ldr_ack` is high on cycle N+1.
- Odd byte or pair: accepted on cycle N; `ram_req` rises on N+1. If `ram_ack` is sampled on cycle M, `ram_req` is 0 and `ldr_ack` = 1 on M+1.
- The earliest acceptable `ram_ack` is the cycle `ram_req` is first high. A `ram_ack` seen while `ram_req` = 0 is ignored.
- At most one RAM write is outstanding. Throughput is bounded by arbiter latency.
- `ldr_aen` falling while in WRITE: no extra action. Falling while in HOLD: the flush `ram_req` rises on the next cycle.
- Reset asserted mid-WRITE: `ram_req` drops immediately (asynchronously). The held byte is lost. No ack is issued.

## Configuration
- `LDR_CHECKSUM_EN` defined: `csum` adds each accepted byte, zero-extended, modulo 2^16. It is updated the cycle after accept and cleared on reset and on `ldr_aen` rising.
- `LDR_CHECKSUM_EN` undefined: no adder is built and `csum` is tied to 16'h0000.

## Test plan
- Pair: bytes 0x00000 = 0x12 and 0x00001 = 0x34 -> one write, addr 0, wdat 0x1234, be 11; two `ldr_ack` pulses.
- Lone odd byte: 0x00003 = 0xAB -> write at addr 1, wdat 0x00AB, be 01; ack after `ram_ack`.
- Non-consecutive even bytes: 0x00010 = 0x55 then 0x00020 = 0x66, then `ldr_aen` falls -> write (8, 0x5500, 10), then write (0x10, 0x6600, 10); 2 acks in total.
- Double-accept guard: `ldr_wr` held high for 4 cycles after the ack of byte 0x00000 -> exactly one accept and one `ldr_ack`.
- Reset mid-WRITE, with `ram_ack` withheld: `ram_req` drops within the reset cycle and all outputs are 0. After release, a new pair is written correctly.
- With `LDR_CHECKSUM_EN`: bytes 0xFF, 0xFF, 0x02 -> `csum` = 0x0200. Without it: `csum` = 0.

Source files
------------

// File: rtl/x68k_ldr_sink.sv
// x68k_ldr_sink
// Responder end of the loader byte-write handshake. Bytes from the HPS
// loader are packed into big-endian 16-bit words and written one word at
// a time to the SDRAM arbiter's loader port. Each byte is acknowledged
// back to the loader exactly once.
//
// Optional feature: define LDR_CHECKSUM_EN to build the running byte sum
// on csum. Without it csum is tied to zero.
//
// Ports:
//   sysclk    system clock, rising edge
//   rstn      asynchronous active-low reset
//   ldr_aen   loader window open; falling edge flushes a held byte
//   ldr_addr  byte address (bit 0 = 0 is the even/upper byte)
//   ldr_wdat  byte data
//   ldr_wr    level request from the loader, held until ldr_ack
//   ldr_ack   one-cycle byte-commit pulse
//   ram_req   write request, held until ram_ack
//   ram_ack   one-cycle completion from the arbiter
//   ram_addr  word address
//   ram_wdat  word data, even byte in [15:8], disabled lanes zero
//   ram_be    byte enables, [1] upper / [0] lower
//   busy      high whenever the FSM is not in IDLE
//   csum      running byte sum (zero unless LDR_CHECKSUM_EN)
module x68k_ldr_sink #(
  parameter int ADDR_W = 20
) (
  input  logic              sysclk,
  input  logic              rstn,
  input  logic              ldr_aen,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdat,
  input  logic              ldr_wr,
  output logic              ldr_ack,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [15:0]       ram_wdat,
  output logic [1:0]        ram_be,
  output logic              busy,
  output logic [15:0]       csum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-2:0] hold_addr_q, hold_addr_d;
  logic [7:0]        hold_dat_q, hold_dat_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_dat_q, pend_dat_d;
  logic [ADDR_W-2:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_dat_q, wr_dat_d;
  logic [1:0]        wr_be_q, wr_be_d;
  logic              owe_q, owe_d;

  logic              take;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_dat;

  // armed blocks a still-high ldr_wr from being taken a second time
  assign take = ldr_wr & ldr_aen & armed_q;

  // In IDLE a byte left pending by a flush wins over a fresh request
  assign sel_addr = pend_q ? pend_addr_q : ldr_addr;
  assign sel_dat  = pend_q ? pend_dat_q  : ldr_wdat;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      ack_q       <= 1'b0;
      hold_addr_q <= '0;
      hold_dat_q  <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_dat_q  <= '0;
      wr_addr_q   <= '0;
      wr_dat_q    <= '0;
      wr_be_q     <= '0;
      owe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      ack_q       <= ack_d;
      hold_addr_q <= hold_addr_d;
      hold_dat_q  <= hold_dat_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_dat_q  <= pend_dat_d;
      wr_addr_q   <= wr_addr_d;
      wr_dat_q    <= wr_dat_d;
      wr_be_q     <= wr_be_d;
      owe_q       <= owe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    ack_d       = 1'b0;
    hold_addr_d = hold_addr_q;
    hold_dat_d  = hold_dat_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_dat_d  = pend_dat_q;
    wr_addr_d   = wr_addr_q;
    wr_dat_d    = wr_dat_q;
    wr_be_d     = wr_be_q;
    owe_d       = owe_q;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q || take) begin
          accept = !pend_q;
          pend_d = 1'b0;
          if (!sel_addr[0]) begin
            hold_addr_d = sel_addr[ADDR_W-1:1];
            hold_dat_d  = sel_dat;
            ack_d       = 1'b1;
            state_d     = HOLD;
          end else begin
            // lone odd byte: its ack waits for the RAM write
            wr_addr_d = sel_addr[ADDR_W-1:1];
            wr_dat_d  = {8'h00, sel_dat};
            wr_be_d   = 2'b01;
            owe_d     = 1'b1;
            state_d   = WRITE;
          end
        end
      end

      HOLD: begin
        if (take) begin
          accept = 1'b1;
          if (ldr_addr[0] && (ldr_addr[ADDR_W-1:1] == hold_addr_q)) begin
            wr_addr_d = hold_addr_q;
            wr_dat_d  = {hold_dat_q, ldr_wdat};
            wr_be_d   = 2'b11;
            owe_d     = 1'b1;
          end else begin
            // flush the held byte; the new one waits and is acked from IDLE
            wr_addr_d   = hold_addr_q;
            wr_dat_d    = {hold_dat_q, 8'h00};
            wr_be_d     = 2'b10;
            owe_d       = 1'b0;
            pend_d      = 1'b1;
            pend_addr_d = ldr_addr;
            pend_dat_d  = ldr_wdat;
          end
          state_d = WRITE;
        end else if (!ldr_aen) begin
          wr_addr_d = hold_addr_q;
          wr_dat_d  = {hold_dat_q, 8'h00};
          wr_be_d   = 2'b10;
          owe_d     = 1'b0;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        if (ram_ack) begin
          ack_d   = owe_q;
          owe_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (accept) armed_d = 1'b0;
    if (!ldr_wr) armed_d = 1'b1;
  end

  assign ldr_ack  = ack_q;
  assign ram_req  = (state_q == WRITE);
  assign ram_addr = wr_addr_q;
  assign ram_wdat = wr_dat_q;
  assign ram_be   = wr_be_q;
  assign busy     = (state_q != IDLE);

`ifdef LDR_CHECKSUM_EN
  logic        aen_q;
  logic [15:0] csum_q;

  // Sum restarts when a new loader window opens
  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      aen_q  <= 1'b0;
      csum_q <= '0;
    end else begin
      aen_q <= ldr_aen;
      if (ldr_aen && !aen_q)
        csum_q <= accept ? {8'h00, ldr_wdat} : 16'h0000;
      else if (accept)
        csum_q <= csum_q + {8'h00, ldr_wdat};
    end
  end

  assign csum = csum_q;
`else
  assign csum = 16'h0000;
`endif

endmodule

// File: tb/tb_x68k_ldr_sink.sv
// tb_x68k_ldr_sink
// Directed bench for x68k_ldr_sink. A loader task drives the ldr_wr
// handshake, a RAM responder answers ram_req (automatically after a short
// latency, or under direct control of a test), and a monitor counts
// ldr_ack pulses. Written words are logged for comparison against
// hand-computed values.
module tb_x68k_ldr_sink;

  logic        sysclk;
  logic        rstn;
  logic        ldr_aen;
  logic [19:0] ldr_addr;
  logic [7:0]  ldr_wdat;
  logic        ldr_wr;
  logic        ldr_ack;
  logic        ram_req;
  logic        ram_ack;
  logic [18:0] ram_addr;
  logic [15:0] ram_wdat;
  logic [1:0]  ram_be;
  logic        busy;
  logic [15:0] csum;

  int passed = 0;
  int total  = 0;
  int ack_cnt = 0;

  bit manual = 0;
  bit man_ack = 0;
  int ack_delay = 1;

  logic [18:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [1:0]  wb_q[$];

  x68k_ldr_sink #(.ADDR_W(20)) dut (
    .sysclk   (sysclk),
    .rstn     (rstn),
    .ldr_aen  (ldr_aen),
    .ldr_addr (ldr_addr),
    .ldr_wdat (ldr_wdat),
    .ldr_wr   (ldr_wr),
    .ldr_ack  (ldr_ack),
    .ram_req  (ram_req),
    .ram_ack  (ram_ack),
    .ram_addr (ram_addr),
    .ram_wdat (ram_wdat),
    .ram_be   (ram_be),
    .busy     (busy),
    .csum     (csum)
  );

  initial sysclk = 0;
  always #5 sysclk = ~sysclk;

  // Counts ldr_ack pulses, sampled mid-cycle
  initial begin
    forever begin
      @(negedge sysclk);
      if (ldr_ack) ack_cnt++;
    end
  end

  // RAM responder: acks after ack_delay cycles of ram_req, or follows
  // man_ack when a test takes direct control. Logs every acked write.
  initial begin
    int cnt;
    cnt = 0;
    ram_ack = 0;
    forever begin
      @(negedge sysclk);
      #1;
      if (manual) begin
        ram_ack = man_ack;
        cnt = 0;
      end else begin
        ram_ack = 0;
        if (ram_req) begin
          if (cnt >= ack_delay) begin
            ram_ack = 1;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end
      if (ram_ack && ram_req) begin
        wa_q.push_back(ram_addr);
        wd_q.push_back(ram_wdat);
        wb_q.push_back(ram_be);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one byte and waits (bounded) for its ack; called just after a negedge
  task automatic send_byte(input logic [19:0] a, input logic [7:0] d, output bit ok);
    ldr_addr = a;
    ldr_wdat = d;
    ldr_wr   = 1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge sysclk);
      if (ldr_ack) ok = 1;
    end
    ldr_wr = 0;
    @(negedge sysclk);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wb_q.delete();
  endtask

  task automatic test_reset();
    rstn = 0; ldr_aen = 1; ldr_wr = 0; ldr_addr = '0; ldr_wdat = '0;
    repeat (3) @(negedge sysclk);
    total++;
    if ({ldr_ack, ram_req, busy, ram_addr, ram_wdat, ram_be, csum} !== '0)
      $display("[TB] FAIL reset_outputs: got req=%b ack=%b busy=%b addr=%h wdat=%h be=%b csum=%h required all 0",
               ram_req, ldr_ack, busy, ram_addr, ram_wdat, ram_be, csum);
    else passed++;
    rstn = 1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_pair();
    bit ok1, ok2;
    int base;
    clear_log();
    base = ack_cnt;
    send_byte(20'h00000, 8'h12, ok1);
    send_byte(20'h00001, 8'h34, ok2);
    repeat (3) @(negedge sysclk);
    total++;
    if (!(ok1 && ok2)) $display("[TB] FAIL pair_handshake: got ok=%b%b required 11", ok1, ok2); else passed++;
    total++;
    if (wa_q.size() !== 1) $display("[TB] FAIL pair_count: got %0d writes required 1", wa_q.size()); else passed++;
    total++;
    if ({wa_q[0], wd_q[0], wb_q[0]} !== {19'h0, 16'h1234, 2'b11})
      $display("[TB] FAIL pair_write: got %h/%h/%b required 0/1234/11", wa_q[0], wd_q[0], wb_q[0]);
    else passed++;
    total++;
    if (ack_cnt - base !== 2) $display("[TB] FAIL pair_acks: got %0d required 2", ack_cnt - base); else passed++;
  endtask

  task automatic test_lone_odd();
    bit ok;
    int base;
    clear_log();
    base = ack_cnt;
    send_byte(20'h00003, 8'hAB, ok);
    repeat (2) @(negedge sysclk);
    total++;
    if (!ok || wa_q.size() !== 1 || {wa_q[0], wd_q[0], wb_q[0]} !== {19'h1, 16'h00AB, 2'b01})
      $display("[TB] FAIL lone_odd_write: got ok=%b n=%0d %h/%h/%b required 1/00AB/01",
               ok, wa_q.size(), wa_q[0], wd_q[0], wb_q[0]);
    else passed++;
    total++;
    if (ack_cnt - base !== 1 || busy !== 1'b0)
      $display("[TB] FAIL lone_odd_ack: got acks=%0d busy=%b required 1/0", ack_cnt - base, busy);
    else passed++;
  endtask

  task automatic test_non_consecutive();
    bit ok1, ok2;
    int base;
    clear_log();
    base = ack_cnt;
    send_byte(20'h00010, 8'h55, ok1);
    send_byte(20'h00020, 8'h66, ok2);
    ldr_aen = 0;
    repeat (8) @(negedge sysclk);
    total++;
    if (!(ok1 && ok2) || wa_q.size() !== 2)
      $display("[TB] FAIL noncons_count: got ok=%b%b writes=%0d required 11/2", ok1, ok2, wa_q.size());
    else passed++;
    total++;
    if ({wa_q[0], wd_q[0], wb_q[0]} !== {19'h8, 16'h5500, 2'b10})
      $display("[TB] FAIL noncons_first: got %h/%h/%b required 8/5500/10", wa_q[0], wd_q[0], wb_q[0]);
    else passed++;
    total++;
    if ({wa_q[1], wd_q[1], wb_q[1]} !== {19'h10, 16'h6600, 2'b10})
      $display("[TB] FAIL noncons_second: got %h/%h/%b required 10/6600/10", wa_q[1], wd_q[1], wb_q[1]);
    else passed++;
    total++;
    if (ack_cnt - base !== 2 || busy !== 1'b0)
      $display("[TB] FAIL noncons_acks: got acks=%0d busy=%b required 2/0", ack_cnt - base, busy);
    else passed++;
    ldr_aen = 1;
    @(negedge sysclk);
  endtask

  task automatic test_window_closed();
    int base;
    base = ack_cnt;
    ldr_aen = 0;
    ldr_addr = 20'h00007; ldr_wdat = 8'h99; ldr_wr = 1;
    repeat (4) @(negedge sysclk);
    total++;
    if (ack_cnt - base !== 0 || ram_req !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL aen_ignore: got acks=%0d req=%b busy=%b required 0/0/0", ack_cnt - base, ram_req, busy);
    else passed++;
    ldr_wr = 0;
    ldr_aen = 1;
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_double_accept();
    int base;
    clear_log();
    base = ack_cnt;
    ldr_addr = 20'h00000; ldr_wdat = 8'h5A; ldr_wr = 1;
    repeat (6) @(negedge sysclk);
    ldr_wr = 0;
    @(negedge sysclk);
    total++;
    if (ack_cnt - base !== 1 || busy !== 1'b1 || wa_q.size() !== 0)
      $display("[TB] FAIL double_accept: got acks=%0d busy=%b writes=%0d required 1/1/0",
               ack_cnt - base, busy, wa_q.size());
    else passed++;
    ldr_aen = 0;
    repeat (5) @(negedge sysclk);
    total++;
    if (wa_q.size() !== 1 || {wa_q[0], wd_q[0], wb_q[0]} !== {19'h0, 16'h5A00, 2'b10})
      $display("[TB] FAIL double_flush: got n=%0d %h/%h/%b required 1 0/5A00/10",
               wa_q.size(), wa_q[0], wd_q[0], wb_q[0]);
    else passed++;
    ldr_aen = 1;
    @(negedge sysclk);
  endtask

  task automatic test_timing();
    manual = 1; man_ack = 0;
    ldr_addr = 20'h00050; ldr_wdat = 8'h11; ldr_wr = 1;
    @(negedge sysclk);
    total++;
    if (ldr_ack !== 1'b1) $display("[TB] FAIL even_ack_latency: got %b required 1", ldr_ack); else passed++;
    ldr_wr = 0;
    @(negedge sysclk);
    ldr_addr = 20'h00051; ldr_wdat = 8'h22; ldr_wr = 1;
    @(negedge sysclk);
    total++;
    if ({ram_req, ldr_ack, ram_addr, ram_wdat, ram_be} !== {1'b1, 1'b0, 19'h28, 16'h1122, 2'b11})
      $display("[TB] FAIL pair_req_rise: got req=%b ack=%b %h/%h/%b required 1 0 28/1122/11",
               ram_req, ldr_ack, ram_addr, ram_wdat, ram_be);
    else passed++;
    man_ack = 1;
    @(negedge sysclk);
    man_ack = 0;
    total++;
    if (ram_req !== 1'b0 || ldr_ack !== 1'b1)
      $display("[TB] FAIL ram_ack_response: got req=%b ack=%b required 0/1", ram_req, ldr_ack);
    else passed++;
    ldr_wr = 0;
    @(negedge sysclk);
    man_ack = 1;
    @(negedge sysclk);
    man_ack = 0;
    @(negedge sysclk);
    total++;
    if (ram_req !== 1'b0 || ldr_ack !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL stray_ram_ack: got req=%b ack=%b busy=%b required 0/0/0", ram_req, ldr_ack, busy);
    else passed++;
    manual = 0;
    @(negedge sysclk);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int base;
    manual = 1; man_ack = 0;
    send_byte(20'h00040, 8'hA1, ok);
    base = ack_cnt;
    ldr_addr = 20'h00041; ldr_wdat = 8'hB2; ldr_wr = 1;
    @(negedge sysclk);
    total++;
    if (ram_req !== 1'b1 || !ok) $display("[TB] FAIL midwrite_setup: got req=%b ok=%b required 1/1", ram_req, ok); else passed++;
    #2 rstn = 0;
    #1;
    total++;
    if ({ldr_ack, ram_req, busy, ram_addr, ram_wdat, ram_be, csum} !== '0)
      $display("[TB] FAIL async_reset: got req=%b ack=%b busy=%b addr=%h wdat=%h be=%b required all 0",
               ram_req, ldr_ack, busy, ram_addr, ram_wdat, ram_be);
    else passed++;
    ldr_wr = 0;
    @(negedge sysclk);
    rstn = 1;
    manual = 0;
    @(negedge sysclk);
    clear_log();
    total++;
    if (ack_cnt - base !== 0) $display("[TB] FAIL reset_no_ack: got %0d acks required 0", ack_cnt - base); else passed++;
    send_byte(20'h00000, 8'hC3, ok);
    send_byte(20'h00001, 8'hD4, ok);
    repeat (2) @(negedge sysclk);
    total++;
    if (ack_cnt - base !== 2 || wa_q.size() !== 1 || {wa_q[0], wd_q[0], wb_q[0]} !== {19'h0, 16'hC3D4, 2'b11})
      $display("[TB] FAIL after_reset_pair: got acks=%0d n=%0d %h/%h/%b required 2 1 0/C3D4/11",
               ack_cnt - base, wa_q.size(), wa_q[0], wd_q[0], wb_q[0]);
    else passed++;
  endtask

  task automatic test_checksum();
    bit ok;
    logic [15:0] exp_csum;
`ifdef LDR_CHECKSUM_EN
    exp_csum = 16'h0200;
`else
    exp_csum = 16'h0000;
`endif
    ack_delay = 2;
    ldr_aen = 0;
    @(negedge sysclk);
    ldr_aen = 1;
    @(negedge sysclk);
    send_byte(20'h00030, 8'hFF, ok);
    send_byte(20'h00031, 8'hFF, ok);
    send_byte(20'h00032, 8'h02, ok);
    total++;
    if (csum !== exp_csum) $display("[TB] FAIL checksum: got %h required %h", csum, exp_csum); else passed++;
    ldr_aen = 0;
    @(negedge sysclk);
    total++;
    if (ram_req !== 1'b1 || ram_be !== 2'b10 || ram_wdat !== 16'h0200)
      $display("[TB] FAIL aen_fall_flush: got req=%b be=%b wdat=%h required 1/10/0200", ram_req, ram_be, ram_wdat);
    else passed++;
    repeat (5) @(negedge sysclk);
    ldr_aen = 1;
    ack_delay = 1;
    @(negedge sysclk);
  endtask

  initial begin
    test_reset();
    test_pair();
    test_lone_odd();
    test_non_consecutive();
    test_window_closed();
    test_double_accept();
    test_timing();
    test_reset_mid_write();
    test_checksum();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
